crossbar_readout: RTL
=====================

// Module: crossbar_readout
// PURPOSE
//   Read-side counterpart of the crossbar load register: captures an N-bit crossbar
//   row/result vector on a PIM_read strobe and streams it out LSB-first in W-bit beats.
//   Uses a valid/ready handshake toward the host/output path.
//   Sits between the PIM crossbar array outputs and the controller result bus.
// PARAMETERS
//   N  10  width of captured crossbar vector
//   W  2   beat width; W>=1, W<=N; beats per read = NB = ceil(N/W)
// PORTS
//   clk         in   1     rising-edge clock
//   rst         in   1     synchronous reset, active-high
//   PIM_read    in   1     capture strobe; sampled only in IDLE
//   D           in   N     crossbar vector to read out
//   busy        out  1     1 while a vector is being streamed (state SEND)
//   out_data    out  W     current beat
//   out_valid   out  1     beat valid
//   out_ready   in   1     consumer accepts beat when out_valid&&out_ready
//   out_last    out  1     1 with the final beat (index NB-1)
//   out_parity  out  1     even parity of out_data (see CONFIGURATION)
//   done        out  1     one-cycle pulse after final beat accepted
//   overrun     out  1     sticky: PIM_read seen while not IDLE
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): state=IDLE, beat index=0, shadow=0; all outputs 0.
//     Reset mid-stream aborts immediately; no done pulse; overrun cleared.
//   - States: IDLE, SEND.
//   - IDLE: PIM_read=1 -> shadow<=D, index<=0, state<=SEND. out_valid rises the next cycle.
//     The latency from strobe to first valid beat is 1 cycle.
//   - SEND: out_valid=1, busy=1.
//     out_data=shadow[idx*W +: W], with bits beyond N-1 zero-padded.
//     out_last=(idx==NB-1).
//   - Handshake: on out_valid&&out_ready, idx<=idx+1.
//     If out_last, state<=IDLE and done<=1 for exactly the next cycle.
//     out_data is held stable while out_ready=0. Unlimited stall is allowed.
//   - idx counter width = $clog2(NB) (min 1). idx never exceeds NB-1 and resets to 0 on return to IDLE.
//   - NB=1 (W>=N): single beat with out_last=1 on that beat.
//   - PIM_read while in SEND, including on the final handshake cycle, is ignored.
//     It sets overrun<=1, which is cleared only by rst.
//     D is never re-sampled mid-stream.
//   - The done cycle is IDLE: a PIM_read during that cycle is accepted normally, with no overrun.
//   - done and out_valid are never high in the same cycle.
// CONFIGURATION
//   CROSSBAR_READOUT_PARITY_EN
//     defined:   out_parity = ^out_data, combinational from the held beat.
//                Valid only when out_valid=1; 0 otherwise.
//     undefined: out_parity tied 0; no parity logic. Port list is unchanged.
// TESTING  (N=10, W=4 unless stated; NB=3)
//   1. rst, then PIM_read=1 with D=10'h2B5, out_ready=1
//      -> beats 4'h5, 4'hB, 4'h2 on 3 consecutive cycles.
//      out_last only on 4'h2; done pulses the following cycle; busy=0 after.
//   2. Same D, out_ready low for 5 cycles on beat 1
//      -> out_data stays 4'hB and out_valid stays 1 while stalled.
//      Stream resumes; total beats=3.
//   3. PIM_read pulsed during beat 0 with D=10'h3FF -> overrun=1.
//      Streamed beats remain 5,B,2; overrun stays 1 until rst.
//   4. PIM_read on the done cycle with D=10'h001
//      -> new stream 4'h1, 4'h0, 4'h0 with overrun=0.
//   5. rst asserted during beat 1 -> next cycle out_valid=0, busy=0, done=0.
//      The next PIM_read restarts at beat 0.
//   6. PARITY_EN defined, D=10'h2B5 -> out_parity 0,1,1.
//      With W=10, D=10'h2B5 -> one beat 10'h2B5, out_last=1, parity 0.

Source files
------------

// File: rtl/crossbar_readout.sv
// -----------------------------------------------------------------------------
// crossbar_readout
//
// Purpose:
//   Read-side counterpart of the crossbar load register. A PIM_read strobe
//   in IDLE captures an N-bit crossbar row/result vector into a shadow
//   register. The vector is then streamed out LSB-first as W-bit beats over a
//   valid/ready handshake. The number of beats per read is NB = ceil(N/W).
//   The final beat is zero-padded above bit N-1.
//
// Optional feature:
//   CROSSBAR_READOUT_PARITY_EN
//      When defined, out_parity carries the even parity (^out_data) of the
//      current beat while out_valid=1, and is 0 otherwise.
//      When undefined, out_parity is tied to 0. The port list is unchanged.
//
// Ports:
//   clk         in   1   rising-edge clock
//   rst         in   1   synchronous reset, active-high
//   PIM_read    in   1   capture strobe, acted on only in IDLE
//   D           in   N   crossbar vector to read out
//   busy        out  1   high while streaming (SEND)
//   out_data    out  W   current beat
//   out_valid   out  1   beat valid
//   out_ready   in   1   consumer accepts the beat when out_valid && out_ready
//   out_last    out  1   high with the final beat (index NB-1)
//   out_parity  out  1   even parity of out_data (see optional feature)
//   done        out  1   one-cycle pulse after the final beat is accepted
//   overrun     out  1   sticky flag: PIM_read seen while not IDLE
// -----------------------------------------------------------------------------
module crossbar_readout #(
   parameter int N = 10,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         PIM_read,
   input  logic [N-1:0] D,
   output logic         busy,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last,
   output logic         out_parity,
   output logic         done,
   output logic         overrun
);

   localparam int NB = (N + W - 1) / W;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   localparam int SW = NB * W;
   localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [IW-1:0] idx;
   logic [SW-1:0] shadow;
   logic          fire;

   assign fire = out_valid && out_ready;

   // State register and datapath.
   // The shadow register is sized to a whole number of beats. This makes the
   // padding bits of the final beat always read as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         shadow  <= '0;
         done    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state <= state_next;
         done  <= (state == SEND) && fire && out_last;
         if ((state == IDLE) && PIM_read) begin
            shadow <= SW'(D);
            idx    <= '0;
         end else if (fire) begin
            idx <= out_last ? '0 : idx + 1'b1;
         end
         // A strobe that arrives mid-stream is dropped. It is remembered here
         // until the next reset.
         if ((state != IDLE) && PIM_read) begin
            overrun <= 1'b1;
         end
      end
   end

   // Next-state logic.
   // The done cycle is already IDLE, so a strobe in that cycle starts a new
   // stream.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (PIM_read) state_next = SEND;
         SEND: if (fire && out_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic.
   // Beat outputs are driven only in SEND. Because idx only advances on a
   // handshake, the beat stays stable while the consumer stalls.
   always_comb begin
      busy      = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      if (state == SEND) begin
         busy      = 1'b1;
         out_valid = 1'b1;
         out_data  = shadow[idx*W +: W];
         out_last  = (idx == LAST_IDX);
      end
   end

`ifdef CROSSBAR_READOUT_PARITY_EN
   assign out_parity = out_valid ? ^out_data : 1'b0;
`else
   assign out_parity = 1'b0;
`endif

endmodule
